// File: rtl/scrambler_64b66b_lanes.sv
`default_nettype none
// ============================================================================
// Module      : scrambler_64b66b_lanes
// Description : Multi-lane self-synchronising 64b/66b scrambler/descrambler.
//               Polynomial G(x) = 1 + x^39 + x^58, independent 58-bit state
//               per lane, sync header forwarded unscrambled. One register
//               stage from input beat to output beat.
// Revision    : 1.0 - initial release
// ============================================================================
module scrambler_64b66b_lanes #(
  parameter int          LEN        = 32,
  parameter int          LANES      = 1,
  parameter int          DESCRAMBLE = 0,
  parameter logic [57:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 valid_i,
  input  logic [LANES*LEN-1:0] data_i,
  input  logic [LANES-1:0]     head_v_i,
  input  logic [2*LANES-1:0]   head_i,
  input  logic [LANES-1:0]     bypass_i,
  input  logic                 seed_ld_i,
  input  logic [57:0]          seed_i,
  output logic                 valid_o,
  output logic [LANES*LEN-1:0] data_o,
  output logic [LANES-1:0]     head_v_o,
  output logic [2*LANES-1:0]   head_o
);

  // RX mode shifts the received bit into the state, TX mode the sent bit.
  localparam bit c_DESCR = (DESCRAMBLE != 0);

  logic [LANES*LEN-1:0] w_data;

  logic                 r_valid;
  logic [LANES*LEN-1:0] r_data;
  logic [LANES-1:0]     r_head_v;
  logic [2*LANES-1:0]   r_head;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [57:0]    r_state;
      logic [LEN-1:0] w_in;
      logic [LEN-1:0] w_scr;
      logic [57:0]    w_next;

      assign w_in = data_i[k*LEN +: LEN];

      // Unrolled bit-serial LFSR; for LEN > 39 later bits see feedback
      // produced by earlier bits of the same beat, which the chain handles.
      always_comb begin
        w_next = r_state;
        w_scr  = '0;
        for (int i = 0; i < LEN; i++) begin
          w_scr[i] = w_in[i] ^ w_next[38] ^ w_next[57];
          w_next   = {w_next[56:0], (c_DESCR ? w_in[i] : w_scr[i])};
        end
      end

      // Lane state: seed load beats the beat advance; bypass freezes the lane.
      always_ff @(posedge clk) begin
        if (!nreset) begin
          r_state <= SEED;
        end else if (seed_ld_i) begin
          r_state <= seed_i;
        end else if (valid_i && !bypass_i[k]) begin
          r_state <= w_next;
        end
      end

      assign w_data[k*LEN +: LEN] = bypass_i[k] ? w_in : w_scr;
    end
  endgenerate

  // Output stage: valid tracks every cycle, payload and header load on valid.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_head_v <= '0;
      r_head   <= '0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_data   <= w_data;
        r_head_v <= head_v_i;
        r_head   <= head_i;
      end
    end
  end

  assign valid_o  = r_valid;
  assign data_o   = r_data;
  assign head_v_o = r_head_v;
  assign head_o   = r_head;

endmodule
`default_nettype wire

// File: tb/tb_scrambler_64b66b_lanes.sv
`default_nettype none
// ============================================================================
// Module      : tb_scrambler_64b66b_lanes
// Description : Self-checking bench for scrambler_64b66b_lanes: directed
//               vector table on a 2x32 TX instance, 4x64 TX->RX loopback,
//               and a 1x40 TX instance against a bit-serial reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scrambler_64b66b_lanes;

  localparam logic [57:0] c_SEED = 58'h3FF_FFFF_FFFF_FFFF;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic        v;
    logic [1:0]  byp;
    logic        sld;
    logic [57:0] sd;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  hv;
    logic [3:0]  hd;
    logic        ev;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  ehv;
    logic [3:0]  ehd;
  } vec_t;

  function automatic vec_t mk(logic rn, logic v, logic [1:0] byp, logic sld, logic [57:0] sd,
                              logic [31:0] d0, logic [31:0] d1, logic [1:0] hv, logic [3:0] hd,
                              logic ev, logic [31:0] e0, logic [31:0] e1, logic [1:0] ehv,
                              logic [3:0] ehd);
    vec_t t;
    t.rn = rn; t.v = v; t.byp = byp; t.sld = sld; t.sd = sd;
    t.d0 = d0; t.d1 = d1; t.hv = hv; t.hd = hd;
    t.ev = ev; t.e0 = e0; t.e1 = e1; t.ehv = ehv; t.ehd = ehd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bit-serial TX reference for the 40-bit instance.
  task automatic tx_model(input logic [39:0] din, input logic [57:0] s_in,
                          output logic [39:0] dout, output logic [57:0] s_out);
    logic [57:0] s;
    s    = s_in;
    dout = '0;
    for (int i = 0; i < 40; i++) begin
      dout[i] = din[i] ^ s[38] ^ s[57];
      s       = {s[56:0], dout[i]};
    end
    s_out = s;
  endtask

  // ---------------- Instance A: TX, 2 lanes x 32 bits ----------------
  logic        a_nrst, a_vld, a_sld, a_vo;
  logic [1:0]  a_byp, a_hv, a_hvo;
  logic [3:0]  a_hd, a_hdo;
  logic [63:0] a_data, a_do;
  logic [57:0] a_seed;

  scrambler_64b66b_lanes #(.LEN(32), .LANES(2), .DESCRAMBLE(0)) u_a (
    .clk(clk), .nreset(a_nrst), .valid_i(a_vld), .data_i(a_data), .head_v_i(a_hv),
    .head_i(a_hd), .bypass_i(a_byp), .seed_ld_i(a_sld), .seed_i(a_seed),
    .valid_o(a_vo), .data_o(a_do), .head_v_o(a_hvo), .head_o(a_hdo));

  // ---------------- Loopback: TX -> RX, 4 lanes x 64 bits ----------------
  logic         t_nrst, t_vld, r_sld, tx_vo, rx_vo;
  logic [255:0] t_data, tx_do, rx_do;
  logic [3:0]   t_hv, tx_hvo, rx_hvo;
  logic [7:0]   t_hd, tx_hdo, rx_hdo;

  scrambler_64b66b_lanes #(.LEN(64), .LANES(4), .DESCRAMBLE(0)) u_tx (
    .clk(clk), .nreset(t_nrst), .valid_i(t_vld), .data_i(t_data), .head_v_i(t_hv),
    .head_i(t_hd), .bypass_i(4'b0000), .seed_ld_i(1'b0), .seed_i(58'h0),
    .valid_o(tx_vo), .data_o(tx_do), .head_v_o(tx_hvo), .head_o(tx_hdo));

  scrambler_64b66b_lanes #(.LEN(64), .LANES(4), .DESCRAMBLE(1)) u_rx (
    .clk(clk), .nreset(t_nrst), .valid_i(tx_vo), .data_i(tx_do), .head_v_i(tx_hvo),
    .head_i(tx_hdo), .bypass_i(4'b0000), .seed_ld_i(r_sld), .seed_i(58'h0),
    .valid_o(rx_vo), .data_o(rx_do), .head_v_o(rx_hvo), .head_o(rx_hdo));

  // ---------------- Instance L: TX, 1 lane x 40 bits ----------------
  logic        l_nrst, l_vld, l_vo;
  logic [39:0] l_data, l_do;
  logic [0:0]  l_hvo;
  logic [1:0]  l_hdo;

  scrambler_64b66b_lanes #(.LEN(40), .LANES(1), .DESCRAMBLE(0)) u_l (
    .clk(clk), .nreset(l_nrst), .valid_i(l_vld), .data_i(l_data), .head_v_i(1'b0),
    .head_i(2'b00), .bypass_i(1'b0), .seed_ld_i(1'b0), .seed_i(58'h0),
    .valid_o(l_vo), .data_o(l_do), .head_v_o(l_hvo), .head_o(l_hdo));

  logic [255:0] q_data [$];
  logic [7:0]   q_hd   [$];
  logic [3:0]   q_hv   [$];

  initial begin
    vec_t         tbl [19];
    int           sent;
    int           got;
    logic [255:0] e_d;
    logic [7:0]   e_hd;
    logic [3:0]   e_hv;
    logic [57:0]  ms;
    logic [39:0]  md;
    logic [63:0]  rnd;

    //            rn v  byp   sld sd      d0            d1            hv    hd     ev e0            e1            ehv   ehd
    tbl[0]  = mk(0, 1, 2'b00, 0, 58'h0,   32'hAAAAAAAA, 32'h55555555, 2'b11, 4'hF, 0, 32'h0,        32'h0,        2'b00, 4'h0);
    tbl[1]  = mk(1, 1, 2'b00, 0, 58'h0,   32'h0,        32'h0,        2'b11, 4'h9, 1, 32'h0,        32'h0,        2'b11, 4'h9);
    tbl[2]  = mk(1, 0, 2'b00, 0, 58'h0,   32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 4'h6, 0, 32'h0,        32'h0,        2'b11, 4'h9);
    tbl[3]  = mk(1, 1, 2'b00, 0, 58'h0,   32'h0,        32'h0,        2'b01, 4'h6, 1, 32'h03FFFF80, 32'h03FFFF80, 2'b01, 4'h6);
    tbl[4]  = mk(1, 1, 2'b00, 0, 58'h0,   32'h0,        32'h0,        2'b10, 4'h2, 1, 32'hFFFFC000, 32'hFFFFC000, 2'b10, 4'h2);
    tbl[5]  = mk(1, 1, 2'b00, 0, 58'h0,   32'h0,        32'h0,        2'b00, 4'h0, 1, 32'hFFEFFFFF, 32'hFFEFFFFF, 2'b00, 4'h0);
    tbl[6]  = mk(0, 1, 2'b00, 0, 58'h0,   32'h0,        32'h0,        2'b11, 4'hA, 0, 32'h0,        32'h0,        2'b00, 4'h0);
    tbl[7]  = mk(1, 1, 2'b01, 0, 58'h0,   32'hDEADBEEF, 32'h0,        2'b01, 4'h1, 1, 32'hDEADBEEF, 32'h0,        2'b01, 4'h1);
    tbl[8]  = mk(1, 1, 2'b01, 0, 58'h0,   32'h12345678, 32'h0,        2'b01, 4'h1, 1, 32'h12345678, 32'h03FFFF80, 2'b01, 4'h1);
    tbl[9]  = mk(1, 1, 2'b01, 0, 58'h0,   32'hCAFEF00D, 32'h0,        2'b10, 4'h4, 1, 32'hCAFEF00D, 32'hFFFFC000, 2'b10, 4'h4);
    tbl[10] = mk(1, 1, 2'b00, 0, 58'h0,   32'h0,        32'h0,        2'b10, 4'h4, 1, 32'h0,        32'hFFEFFFFF, 2'b10, 4'h4);
    tbl[11] = mk(1, 1, 2'b10, 0, 58'h0,   32'h0,        32'h0F0F0F0F, 2'b01, 4'h5, 1, 32'h03FFFF80, 32'h0F0F0F0F, 2'b01, 4'h5);
    tbl[12] = mk(1, 1, 2'b00, 0, 58'h0,   32'h0,        32'h0,        2'b01, 4'h5, 1, 32'hFFFFC000, 32'h080000FF, 2'b01, 4'h5);
    tbl[13] = mk(0, 1, 2'b00, 0, 58'h0,   32'h0,        32'h0,        2'b00, 4'h0, 0, 32'h0,        32'h0,        2'b00, 4'h0);
    tbl[14] = mk(1, 1, 2'b00, 0, 58'h0,   32'h13579BDF, 32'h0,        2'b10, 4'h8, 1, 32'h13579BDF, 32'h0,        2'b10, 4'h8);
    tbl[15] = mk(1, 1, 2'b01, 1, 58'h155, 32'h2468ACE0, 32'h0,        2'b10, 4'h8, 1, 32'h2468ACE0, 32'h03FFFF80, 2'b10, 4'h8);
    tbl[16] = mk(1, 1, 2'b00, 0, 58'h0,   32'h0,        32'h0,        2'b01, 4'h2, 1, 32'h40000000, 32'h40000000, 2'b01, 4'h2);
    tbl[17] = mk(1, 1, 2'b00, 0, 58'h0,   32'h0,        32'h0,        2'b01, 4'h2, 1, 32'h02AA0055, 32'h02AA0055, 2'b01, 4'h2);
    tbl[18] = mk(1, 0, 2'b00, 0, 58'h0,   32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 4'h0, 0, 32'h02AA0055, 32'h02AA0055, 2'b01, 4'h2);

    a_nrst = 1'b0; a_vld = 1'b0; a_sld = 1'b0; a_byp = '0; a_hv = '0; a_hd = '0;
    a_data = '0; a_seed = '0;
    t_nrst = 1'b0; t_vld = 1'b0; r_sld = 1'b0; t_data = '0; t_hv = '0; t_hd = '0;
    l_nrst = 1'b0; l_vld = 1'b0; l_data = '0;

    @(posedge clk); #1;

    // ---- Directed table on instance A ----
    for (int r = 0; r < 19; r++) begin
      a_nrst = tbl[r].rn;
      a_vld  = tbl[r].v;
      a_byp  = tbl[r].byp;
      a_sld  = tbl[r].sld;
      a_seed = tbl[r].sd;
      a_data = {tbl[r].d1, tbl[r].d0};
      a_hv   = tbl[r].hv;
      a_hd   = tbl[r].hd;
      @(posedge clk); #1;
      chk($sformatf("row%0d valid_o", r), {255'b0, a_vo}, {255'b0, tbl[r].ev});
      chk($sformatf("row%0d lane0", r), {224'b0, a_do[31:0]}, {224'b0, tbl[r].e0});
      chk($sformatf("row%0d lane1", r), {224'b0, a_do[63:32]}, {224'b0, tbl[r].e1});
      chk($sformatf("row%0d head_v_o", r), {254'b0, a_hvo}, {254'b0, tbl[r].ehv});
      chk($sformatf("row%0d head_o", r), {252'b0, a_hdo}, {252'b0, tbl[r].ehd});
    end
    a_vld = 1'b0;

    // ---- TX -> RX loopback, RX seeded to zero ----
    chk("lb reset valid_o", {255'b0, rx_vo}, 256'd0);
    chk("lb reset data_o", rx_do, 256'd0);
    t_nrst = 1'b1;
    r_sld  = 1'b1;
    @(posedge clk); #1;
    r_sld = 1'b0;
    sent  = 0;
    got   = 0;
    for (int c = 0; c < 30; c++) begin
      if (c < 24 && (c % 5) != 3) begin
        t_vld = 1'b1;
        for (int w = 0; w < 8; w++) t_data[w*32 +: 32] = $urandom;
        t_hd = 8'($urandom);
        t_hv = 4'($urandom);
        q_data.push_back(t_data);
        q_hd.push_back(t_hd);
        q_hv.push_back(t_hv);
        sent++;
      end else begin
        t_vld  = 1'b0;
        t_data = '1;
      end
      @(posedge clk); #1;
      if (rx_vo) begin
        if (q_data.size() == 0) begin
          chk("lb unexpected beat", 256'd1, 256'd0);
        end else begin
          e_d  = q_data.pop_front();
          e_hd = q_hd.pop_front();
          e_hv = q_hv.pop_front();
          if (got >= 1) chk($sformatf("lb beat%0d data", got), rx_do, e_d);
          chk($sformatf("lb beat%0d head_o", got), {248'b0, rx_hdo}, {248'b0, e_hd});
          chk($sformatf("lb beat%0d head_v_o", got), {252'b0, rx_hvo}, {252'b0, e_hv});
          got++;
        end
      end
    end
    chk("lb beat count", 256'(got), 256'(sent));
    t_vld = 1'b0;

    // ---- 40-bit lane: in-beat feedback and reference comparison ----
    chk("len40 reset valid_o", {255'b0, l_vo}, 256'd0);
    chk("len40 reset data_o", {216'b0, l_do}, 256'd0);
    chk("len40 reset head", {253'b0, l_hvo, l_hdo}, 256'd0);
    l_nrst = 1'b1;
    l_vld  = 1'b1;
    l_data = '0;
    @(posedge clk); #1;
    chk("len40 beat1 valid_o", {255'b0, l_vo}, 256'd1);
    chk("len40 beat1 data", {216'b0, l_do}, {216'b0, 40'h80_0000_0000});
    ms = c_SEED;
    tx_model(40'h0, ms, md, ms);
    for (int b = 0; b < 100; b++) begin
      rnd    = {$urandom, $urandom};
      l_data = rnd[39:0];
      l_vld  = ((b % 7) != 5);
      if (l_vld) tx_model(l_data, ms, md, ms);
      @(posedge clk); #1;
      chk($sformatf("len40 rand%0d data", b), {216'b0, l_do}, {216'b0, md});
      chk($sformatf("len40 rand%0d valid_o", b), {255'b0, l_vo}, {255'b0, l_vld});
    end
    l_vld = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
